eu_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one execution unit's result-transmit port (addr/req_valid out, data/success back) among NUM_REQ interconnect requesters. It captures one requester's address and holds the grant until the EU reports success, the requester withdraws, or a timeout expires. It then returns the data, or a timeout flag, to that requester. It sits between the interconnect receive side and a single ALU's `icon_tx_*` ports.

---
 rtl/pkg_dtypes.sv | 7 +
 rtl/rr_pick.sv | 32 +++
 rtl/eu_tx_arbiter.sv | 89 ++++++++
 tb/tb_eu_tx_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pkg_dtypes.sv
// pkg_dtypes: datatypes shared between the interconnect and the execution units.
package pkg_dtypes;
  localparam int EU_ADDR_W = 16;
  localparam int EU_DATA_W = 32;
  typedef logic [EU_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EU_DATA_W-1:0] type_exec_unit_data;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or after ptr_i.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);
  logic [IW:0]   s;
  logic [IW-1:0] j;
  // Walk offsets from farthest to nearest so the offset closest to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    s = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, ptr_i} + (IW+1)'(i);
      j = (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : IW'(s);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eu_tx_arbiter.sv
// eu_tx_arbiter: round-robin share of one EU result-transmit port among NUM_REQ requesters,
// holding each grant until success, withdrawal or timeout.
module eu_tx_arbiter
  import pkg_dtypes::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  type_exec_unit_addr [NUM_REQ-1:0]  req_addr_i,
  output type_exec_unit_data                req_data_o,
  output logic [NUM_REQ-1:0]                req_done_o,
  output logic [NUM_REQ-1:0]                req_timeout_o,
  output type_exec_unit_addr                eu_tx_addr_o,
  output logic                              eu_tx_req_valid_o,
  input  type_exec_unit_data                eu_tx_data_i,
  input  logic                              eu_tx_success_i,
  output logic                              busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e             state_q;
  logic [IW-1:0]      ptr_q, g_q, ptr_d, pick_idx;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] done_q, to_q, eligible, pick_gnt;
  logic               pick_any;
  type_exec_unit_addr addr_q, pick_addr;
  type_exec_unit_data data_q;
  // A requester being told done/timeout this cycle must not be re-granted on its stale valid.
  assign eligible = req_valid_i & ~(done_q | to_q);
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) pick_addr = pick_gnt[i] ? req_addr_i[i] : pick_addr;
  end
  assign ptr_d = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= '0;
      to_q    <= '0;
    end else begin
      done_q <= '0;
      to_q   <= '0;
      if (state_q == IDLE) begin
        if (pick_any) begin
          g_q     <= pick_idx;
          addr_q  <= pick_addr;
          cnt_q   <= '0;
          state_q <= GRANT;
        end
      end else if (eu_tx_success_i) begin
        data_q      <= eu_tx_data_i;
        done_q[g_q] <= 1'b1;
        ptr_q       <= ptr_d;
        state_q     <= IDLE;
      end else if (!req_valid_i[g_q]) begin
        ptr_q   <= ptr_d;
        state_q <= IDLE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        to_q[g_q] <= 1'b1;
        ptr_q     <= ptr_d;
        state_q   <= IDLE;
      end else begin
        cnt_q <= (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end
  assign eu_tx_req_valid_o = (state_q == GRANT);
  assign busy_o            = (state_q == GRANT);
  assign eu_tx_addr_o      = addr_q;
  assign req_data_o        = data_q;
  assign req_done_o        = done_q;
  assign req_timeout_o     = to_q;
endmodule

// File: tb/tb_eu_tx_arbiter.sv
// tb_eu_tx_arbiter: scripted EU behaviour with a pulse scoreboard for eu_tx_arbiter.
module tb_eu_tx_arbiter;
  import pkg_dtypes::*;
  typedef struct packed {
    logic [3:0]         to;
    logic [3:0]         done;
    type_exec_unit_data data;
  } exp_t;
  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [3:0]             req_valid = '0;
  type_exec_unit_addr [3:0] req_addr = '0;
  type_exec_unit_data     req_data;
  type_exec_unit_data     eu_data = '0;
  logic [3:0]             req_done, req_to;
  type_exec_unit_addr     eu_addr;
  logic                   eu_valid, busy;
  logic                   eu_success = 1'b0;
  int                     n_vec = 0;
  int                     n_err = 0;
  exp_t                   sb[$];
  exp_t                   e;
  always #5 clk = ~clk;
  eu_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid_i       (req_valid),
    .req_addr_i        (req_addr),
    .req_data_o        (req_data),
    .req_done_o        (req_done),
    .req_timeout_o     (req_to),
    .eu_tx_addr_o      (eu_addr),
    .eu_tx_req_valid_o (eu_valid),
    .eu_tx_data_i      (eu_data),
    .eu_tx_success_i   (eu_success),
    .busy_o            (busy)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] to, input logic [3:0] done, input type_exec_unit_data d);
    sb.push_back({to, done, d});
  endtask
  // Every done/timeout pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset_n && (req_done | req_to) != '0) begin
      if (sb.size() == 0) check("unexpected_pulse", {req_to, req_done}, 64'h0);
      else begin
        e = sb.pop_front();
        check("pulse", {req_to, req_done, (req_done != '0) ? req_data : 32'h0}, e);
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {eu_valid, busy, req_done, req_to}, 64'h0);
    check("rst_addr", eu_addr, 64'h0);
    check("rst_data", req_data, 64'h0);
    reset_n = 1'b1;
    cyc();
    // single requester, success on first GRANT cycle
    req_addr[0] = 16'h1234;
    req_valid = 4'b0001;
    cyc();
    check("s_valid", eu_valid, 1);
    check("s_addr", eu_addr, 16'h1234);
    eu_success = 1'b1;
    eu_data = 32'h5A;
    push(4'b0000, 4'b0001, 32'h5A);
    cyc();
    eu_success = 1'b0;
    req_valid = '0;
    check("s_busy", busy, 0);
    check("s_data", req_data, 32'h5A);
    cyc();
    // timeout on requester 1, then requester 2 granted
    req_addr[1] = 16'h1111;
    req_addr[2] = 16'h2222;
    req_valid = 4'b0110;
    cyc();
    check("to_addr", eu_addr, 16'h1111);
    push(4'b0010, 4'b0000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("to_valid", eu_valid, 1);
      cyc();
    end
    check("to_end", eu_valid, 0);
    req_valid = 4'b0100;
    cyc();
    check("to_next_valid", eu_valid, 1);
    check("to_next_addr", eu_addr, 16'h2222);
    // withdrawal without success
    req_valid = '0;
    cyc();
    check("wd_idle", busy, 0);
    cyc();
    check("wd_stay", busy, 0);
    // withdrawal together with success still delivers done
    req_valid = 4'b0100;
    cyc();
    check("wds_busy", busy, 1);
    req_valid = '0;
    eu_success = 1'b1;
    eu_data = 32'h77;
    push(4'b0000, 4'b0100, 32'h77);
    cyc();
    eu_success = 1'b0;
    check("wds_idle", busy, 0);
    check("wds_data", req_data, 32'h77);
    cyc();
    // success on the last allowed cycle is a done, not a timeout
    req_valid = 4'b0100;
    cyc();
    repeat (7) cyc();
    check("lt_valid", eu_valid, 1);
    eu_success = 1'b1;
    eu_data = 32'h99;
    push(4'b0000, 4'b0100, 32'h99);
    cyc();
    eu_success = 1'b0;
    req_valid = '0;
    check("lt_idle", busy, 0);
    cyc();
    cyc();
    // address captured at grant and held
    req_addr[3] = 16'hAAAA;
    req_valid = 4'b1000;
    cyc();
    check("ac_addr0", eu_addr, 16'hAAAA);
    req_addr[3] = 16'hBBBB;
    cyc();
    check("ac_addr1", eu_addr, 16'hAAAA);
    cyc();
    check("ac_addr2", eu_addr, 16'hAAAA);
    eu_success = 1'b1;
    eu_data = 32'h3C;
    push(4'b0000, 4'b1000, 32'h3C);
    cyc();
    eu_success = 1'b0;
    req_valid = '0;
    check("ac_data", req_data, 32'h3C);
    cyc();
    // reset during GRANT with counter at 3
    req_addr[1] = 16'h5555;
    req_valid = 4'b0010;
    cyc();
    repeat (3) cyc();
    check("mr_pre", eu_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mr_ctrl", {eu_valid, busy, req_done, req_to}, 64'h0);
    check("mr_addr", eu_addr, 64'h0);
    check("mr_data", req_data, 64'h0);
    for (int i = 0; i < 4; i++) req_addr[i] = 16'(16'hA0 + i);
    req_valid = 4'b1111;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    // fairness: all requesting, success on every grant
    for (int k = 0; k < 5; k++) begin
      check("fair_valid", eu_valid, 1);
      check("fair_addr", eu_addr, 16'hA0 + (k % 4));
      eu_success = 1'b1;
      eu_data = 32'(32'hD0 + k);
      push(4'b0000, 4'(1 << (k % 4)), 32'(32'hD0 + k));
      cyc();
      eu_success = 1'b0;
      if (k == 4) req_valid = '0;
      check("fair_gap", busy, 0);
      cyc();
    end
    repeat (3) cyc();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
